// File: rtl/alu_issue_pkg.sv
// Shared decode constants for alu_issue: ALU op codes, opcodes, FSM states and the decoder.
// Latency: n/a (types and a combinational helper function only).
// Backpressure: n/a.
// Optional feature macro: ALU_ISSUE_IMM_EN (adds I-type ALU instruction decode).
package alu_issue_pkg;

    // The ALU's op encoding. The order of these values is fixed by the ALU, not chosen here.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_OR  = 3'd2,
        ALU_XOR = 3'd3,
        ALU_AND = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Source of the second ALU operand.
    typedef enum logic [1:0] {
        D2_RS2    = 2'd0,  // x[rs2]
        D2_RS2_SH = 2'd1,  // x[rs2][4:0], zero-extended (register shifts)
        D2_IMM    = 2'd2,  // sign-extended imm[11:0]
        D2_SHAMT  = 2'd3   // instr[24:20], zero-extended (immediate shifts)
    } d2_sel_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
        d2_sel_e d2_sel;
    } dec_t;

    // Anything not explicitly listed (SRA/SRAI, SLTU/SLTIU, M-extension, other opcodes)
    // comes back with legal = 0.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc      = instr[6:0];
        f3       = instr[14:12];
        f7       = instr[31:25];
        d.legal  = 1'b0;
        d.op     = ALU_ADD;
        d.d2_sel = D2_RS2;
        if (opc == OP_R) begin
            if (f7 == 7'b0000000) begin
                d.legal = 1'b1;
                case (f3)
                    3'b000:  d.op = ALU_ADD;
                    3'b001:  begin d.op = ALU_SLL; d.d2_sel = D2_RS2_SH; end
                    3'b010:  d.op = ALU_SLT;
                    3'b100:  d.op = ALU_XOR;
                    3'b101:  begin d.op = ALU_SRL; d.d2_sel = D2_RS2_SH; end
                    3'b110:  d.op = ALU_OR;
                    3'b111:  d.op = ALU_AND;
                    default: d.legal = 1'b0;
                endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                d.legal = 1'b1;
                d.op    = ALU_SUB;
            end
        end
`ifdef ALU_ISSUE_IMM_EN
        else if (opc == OP_I) begin
            d.d2_sel = D2_IMM;
            case (f3)
                3'b000:  begin d.legal = 1'b1; d.op = ALU_ADD; end
                3'b010:  begin d.legal = 1'b1; d.op = ALU_SLT; end
                3'b100:  begin d.legal = 1'b1; d.op = ALU_XOR; end
                3'b110:  begin d.legal = 1'b1; d.op = ALU_OR;  end
                3'b111:  begin d.legal = 1'b1; d.op = ALU_AND; end
                3'b001:  begin d.legal = (f7 == 7'b0); d.op = ALU_SLL; d.d2_sel = D2_SHAMT; end
                3'b101:  begin d.legal = (f7 == 7'b0); d.op = ALU_SRL; d.d2_sel = D2_SHAMT; end
                default: d.legal = 1'b0;
            endcase
        end
`endif
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x32 integer register file: two combinational read ports, one synchronous write port.
// Latency: reads same cycle; a write is visible to reads after the writing edge.
// Backpressure: none; a write is taken whenever we is high. x0 reads 0, writes to it are dropped.
// Ports: clk, rst (async active-low), rs1/rs2 -> rdata1/rdata2, we/waddr/wdata write port.
// RF_RESET_ZERO = 1 clears all registers on reset; 0 keeps contents across reset.
module alu_issue_regfile #(
    parameter int RF_RESET_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];

    assign rdata1 = (rs1 == 5'd0) ? 32'd0 : mem[rs1];
    assign rdata2 = (rs2 == 5'd0) ? 32'd0 : mem[rs2];

    generate
        if (RF_RESET_ZERO != 0) begin : g_rst
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < 32; i++) begin
                        mem[i] <= '0;
                    end
                end else if (we && waddr != 5'd0) begin
                    mem[waddr] <= wdata;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (we && waddr != 5'd0) begin
                    mem[waddr] <= wdata;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue front end for the registered ALU: decode, read operands, issue, write back.
// Latency: handshake edge T0 -> operands out after T0 -> writeback strobe after T2 (3 cycles/instr).
// Backpressure: instr_ready is high only in IDLE; illegal instructions are consumed in one cycle.
// Ports: clk, rst (async active-low); instr_valid/instr_ready/instr in; alu_op/alu_d1/alu_d2 to
// the ALU, alu_dout back from it; wb_valid/wb_rd/wb_data writeback report; illegal strobe.
// Optional feature macro: ALU_ISSUE_IMM_EN (I-type ALU instructions; illegal when undefined).
// The ALU's own synchronous active-high reset is driven from ~rst by the enclosing level.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int RF_RESET_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_d1,
    output logic [31:0] alu_d2,
    input  logic [31:0] alu_dout,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);

    state_e      state;
    alu_op_e     op_q;
    logic [4:0]  rd_q;
    dec_t        dec;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] d2_nxt;

    assign dec         = decode(instr);
    assign instr_ready = (state == ST_IDLE) && rst;
    assign alu_op      = op_q;

    // Write happens on the WB exit edge, so an instruction handshaking on the very next
    // edge already reads the new value through the combinational read port.
    alu_issue_regfile #(
        .RF_RESET_ZERO(RF_RESET_ZERO)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .rs1    (instr[19:15]),
        .rs2    (instr[24:20]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (state == ST_WB),
        .waddr  (rd_q),
        .wdata  (alu_dout)
    );

    always_comb begin
        d2_nxt = rs2_val;
        case (dec.d2_sel)
            D2_RS2_SH: d2_nxt = {27'd0, rs2_val[4:0]};
`ifdef ALU_ISSUE_IMM_EN
            D2_IMM:    d2_nxt = {{20{instr[31]}}, instr[31:20]};
            D2_SHAMT:  d2_nxt = {27'd0, instr[24:20]};
`endif
            default:   d2_nxt = rs2_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            op_q     <= ALU_ADD;
            alu_d1   <= '0;
            alu_d2   <= '0;
            rd_q     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // rst is high in this branch, so instr_ready reduces to state == IDLE.
                    if (instr_valid) begin
                        if (dec.legal) begin
                            op_q   <= dec.op;
                            alu_d1 <= rs1_val;
                            alu_d2 <= d2_nxt;
                            rd_q   <= instr[11:7];
                            state  <= ST_EXEC;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                // ALU samples op/d1/d2 on this state's exit edge.
                ST_EXEC: state <= ST_WB;
                ST_WB: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= alu_dout;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: plays instruction fetch and the registered ALU, and checks every
// transaction against an architectural model of the integer register file.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [2:0]  alu_op;
    logic [31:0] alu_d1;
    logic [31:0] alu_d2;
    logic [31:0] alu_dout;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    always #5 clk = ~clk;

    alu_issue #(.RF_RESET_ZERO(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_d1      (alu_d1),
        .alu_d2      (alu_d2),
        .alu_dout    (alu_dout),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal)
    );

    // Registered ALU with synchronous active-high reset taken from ~rst. When seed_en is set
    // it returns seed_val instead, which lets the bench load arbitrary register values.
    logic        seed_en = 1'b0;
    logic [31:0] seed_val = 32'd0;
    wire         alu_rst = ~rst;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return a & b;
            3'd5: return a >> b[4:0];
            3'd6: return a << b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_rst)      alu_dout <= 32'd0;
        else if (seed_en) alu_dout <= seed_val;
        else              alu_dout <= alu_fn(alu_op, alu_d1, alu_d2);
    end

    // Architectural state model.
    logic [31:0] xm [32];
    logic [2:0]  last_op;
    logic [31:0] last_d1;
    logic [31:0] last_d2;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // RV32I semantics of the supported subset: legality, expected op code, operands and result.
    task automatic predict(input logic [31:0] ins, output bit legal, output logic [2:0] op,
                           output logic [31:0] a, output logic [31:0] b, output logic [31:0] res);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] v2;
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm   = {{20{ins[31]}}, ins[31:20]};
        a     = xm[ins[19:15]];
        v2    = xm[ins[24:20]];
        legal = 1'b0;
        op    = 3'd0;
        b     = v2;
        res   = 32'd0;
        if (ins[6:0] == 7'b0110011) begin
            if (f7 == 7'h00 && f3 == 3'b000) begin legal = 1; op = 0; res = a + v2; end
            if (f7 == 7'h20 && f3 == 3'b000) begin legal = 1; op = 1; res = a - v2; end
            if (f7 == 7'h00 && f3 == 3'b001) begin legal = 1; op = 6; b = {27'd0, v2[4:0]}; res = a << v2[4:0]; end
            if (f7 == 7'h00 && f3 == 3'b010) begin legal = 1; op = 7; res = ($signed(a) < $signed(v2)) ? 1 : 0; end
            if (f7 == 7'h00 && f3 == 3'b100) begin legal = 1; op = 3; res = a ^ v2; end
            if (f7 == 7'h00 && f3 == 3'b101) begin legal = 1; op = 5; b = {27'd0, v2[4:0]}; res = a >> v2[4:0]; end
            if (f7 == 7'h00 && f3 == 3'b110) begin legal = 1; op = 2; res = a | v2; end
            if (f7 == 7'h00 && f3 == 3'b111) begin legal = 1; op = 4; res = a & v2; end
        end
`ifdef ALU_ISSUE_IMM_EN
        if (ins[6:0] == 7'b0010011) begin
            b = imm;
            if (f3 == 3'b000) begin legal = 1; op = 0; res = a + imm; end
            if (f3 == 3'b010) begin legal = 1; op = 7; res = ($signed(a) < $signed(imm)) ? 1 : 0; end
            if (f3 == 3'b100) begin legal = 1; op = 3; res = a ^ imm; end
            if (f3 == 3'b110) begin legal = 1; op = 2; res = a | imm; end
            if (f3 == 3'b111) begin legal = 1; op = 4; res = a & imm; end
            if (f3 == 3'b001 && f7 == 0) begin legal = 1; op = 6; b = {27'd0, ins[24:20]}; res = a << ins[24:20]; end
            if (f3 == 3'b101 && f7 == 0) begin legal = 1; op = 5; b = {27'd0, ins[24:20]}; res = a >> ins[24:20]; end
        end
`endif
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("instr_ready", 32'(instr_ready), 32'd1);
    endtask

    // One full transaction; wbd returns the observed writeback data (0 for illegal).
    task automatic issue(input logic [31:0] ins, input bit seed, input logic [31:0] sv,
                         output logic [31:0] wbd);
        bit          legal;
        logic [2:0]  op;
        logic [31:0] a, b, res;
        predict(ins, legal, op, a, b, res);
        if (seed) res = sv;
        wbd = 32'd0;
        @(negedge clk);
        wait_ready();
        seed_en     = seed;
        seed_val    = sv;
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("illegal", 32'(illegal), 32'(!legal));
        chk("wb_idle", 32'(wb_valid), 32'd0);
        if (!legal) begin
            chk("op_hold", 32'(alu_op), 32'(last_op));
            chk("d1_hold", alu_d1, last_d1);
            chk("d2_hold", alu_d2, last_d2);
            chk("ready_ill", 32'(instr_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("illegal_clr", 32'(illegal), 32'd0);
            chk("wb_ill", 32'(wb_valid), 32'd0);
        end else begin
            chk("alu_op", 32'(alu_op), 32'(op));
            chk("alu_d1", alu_d1, a);
            chk("alu_d2", alu_d2, b);
            chk("ready_busy", 32'(instr_ready), 32'd0);
            last_op = op;
            last_d1 = a;
            last_d2 = b;
            @(posedge clk);
            #1;
            chk("wb_exec", 32'(wb_valid), 32'd0);
            @(posedge clk);
            #1;
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_rd", 32'(wb_rd), 32'(ins[11:7]));
            chk("wb_data", wb_data, res);
            chk("ready_wb", 32'(instr_ready), 32'd1);
            wbd = wb_data;
            if (ins[11:7] != 5'd0) xm[ins[11:7]] = res;
        end
        seed_en = 1'b0;
    endtask

    task automatic seed_reg(input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] d;
        issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, rd), 1'b1, v, d);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) xm[i] = 32'd0;
        last_op = 3'd0;
        last_d1 = 32'd0;
        last_d2 = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        model_reset();

        // Reset values while rst is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_d1", alu_d1, 32'd0);
        chk("rst_d2", alu_d2, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'd1);

        // Directed sequence.
`ifdef ALU_ISSUE_IMM_EN
        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1'b0, 32'd0, d);
        chk("addi_5", d, 32'd5);
        issue(enc_i(12'hFFD, 5'd0, 3'b000, 5'd2), 1'b0, 32'd0, d);
        chk("addi_m3", d, 32'hFFFF_FFFD);
`else
        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1'b0, 32'd0, d);
        seed_reg(5'd1, 32'd5);
        seed_reg(5'd2, 32'hFFFF_FFFD);
`endif
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 32'd0, d);
        chk("sub_8", d, 32'd8);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4), 1'b0, 32'd0, d);
        chk("slt_1", d, 32'd1);
        seed_reg(5'd5, 32'h8000_0001);
        seed_reg(5'd7, 32'h0000_0021);
        issue(enc_r(7'h00, 5'd7, 5'd5, 3'b001, 5'd6), 1'b0, 32'd0, d);
        chk("sll_2", d, 32'd2);
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd0), 1'b0, 32'd0, d);
        chk("add_x0", d, 32'd10);
        issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd8), 1'b0, 32'd0, d);
        chk("add_zero", d, 32'd0);
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd9), 1'b0, 32'd0, d);   // SRA
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd9), 1'b0, 32'd0, d);   // SLTU
        issue(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd9), 1'b0, 32'd0, d);   // MUL
        issue(enc_i(12'd7, 5'd1, 3'b011, 5'd9), 1'b0, 32'd0, d);         // SLTIU
        issue(enc_i(12'h405, 5'd1, 3'b101, 5'd9), 1'b0, 32'd0, d);       // SRAI

        // Reset asserted while in EXEC abandons the instruction.
        @(negedge clk);
        wait_ready();
        instr       = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd9);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(instr_ready), 32'd0);
        chk("mid_rst_op", 32'(alu_op), 32'd0);
        chk("mid_rst_d1", alu_d1, 32'd0);
        chk("mid_rst_d2", alu_d2, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_wb", 32'(wb_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("mid_rst_idle", 32'(instr_ready), 32'd1);
        issue(enc_r(7'h00, 5'd5, 5'd1, 3'b000, 5'd10), 1'b0, 32'd0, d);
        chk("rf_cleared", d, 32'd0);

        // Randomized phase.
        for (int n = 0; n < 120; n++) begin
            logic [31:0] ins;
            logic [6:0]  f7;
            int          pick;
            pick = $urandom_range(0, 3);
            f7   = (pick < 2) ? 7'h00 : (pick == 2) ? 7'h20 : 7'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                seed_reg(5'($urandom_range(1, 31)), $urandom);
            end else if ($urandom_range(0, 9) < 7) begin
                ins = enc_r(f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
                issue(ins, 1'b0, 32'd0, d);
            end else begin
                ins = enc_i(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
                if ($urandom_range(0, 1) == 0) ins[31:25] = f7;
                issue(ins, 1'b0, 32'd0, d);
            end
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
